// File: rtl/vx_tcu_csr_bridge.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : vx_tcu_csr_bridge                                            |
// | Description : Round-robin bridge from NUM_TCU tensor-core request channels |
// |               onto the CSR file's read/write ports, with a tag pipeline    |
// |               returning read data to per-channel response registers.       |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module vx_tcu_csr_bridge #(
  parameter int NUM_TCU     = 4,
  parameter int DATA_WIDTH  = 32,
  parameter int ADDR_BITS   = 12,
  parameter int TAG_WIDTH   = 4,
  parameter int CSR_LATENCY = 1
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic [NUM_TCU-1:0]              req_valid,
  input  logic [NUM_TCU-1:0]              req_rw,
  input  logic [NUM_TCU*ADDR_BITS-1:0]    req_addr,
  input  logic [NUM_TCU*DATA_WIDTH-1:0]   req_wdata,
  input  logic [NUM_TCU*TAG_WIDTH-1:0]    req_tag,
  output logic [NUM_TCU-1:0]              req_ready,
  output logic [NUM_TCU-1:0]              rsp_valid,
  output logic [NUM_TCU*DATA_WIDTH-1:0]   rsp_data_a,
  output logic [NUM_TCU*DATA_WIDTH-1:0]   rsp_data_b,
  output logic [NUM_TCU*TAG_WIDTH-1:0]    rsp_tag,
  input  logic [NUM_TCU-1:0]              rsp_ready,
  output logic                            csr_read_enable,
  output logic [ADDR_BITS-1:0]            csr_read_addr,
  input  logic [DATA_WIDTH-1:0]           csr_read_data_a,
  input  logic [DATA_WIDTH-1:0]           csr_read_data_b,
  output logic                            csr_write_enable,
  output logic [ADDR_BITS-1:0]            csr_write_addr,
  output logic [DATA_WIDTH-1:0]           csr_write_data
);

  // A 1-bit pointer is kept even for a single channel; it simply never moves.
  localparam int c_ptr_w = (NUM_TCU > 1) ? $clog2(NUM_TCU) : 1;
  // One extra bit so rr + offset cannot overflow before the wrap correction.
  localparam int c_idx_w = c_ptr_w + 1;

  logic [c_ptr_w-1:0]    r_rr;
  logic [NUM_TCU-1:0]    r_busy;
  logic [NUM_TCU-1:0]    w_elig;
  logic [c_idx_w-1:0]    w_idx;
  logic                  w_grant_valid;
  logic [c_ptr_w-1:0]    w_grant_idx;
  logic                  w_grant_rw;
  logic                  w_rd_grant;
  logic                  w_wr_grant;
  logic [ADDR_BITS-1:0]  w_grant_addr;
  logic [DATA_WIDTH-1:0] w_grant_wdata;
  logic [TAG_WIDTH-1:0]  w_grant_tag;

  logic [CSR_LATENCY-1:0] r_pipe_vld;
  logic [c_ptr_w-1:0]     r_pipe_ch  [CSR_LATENCY];
  logic [TAG_WIDTH-1:0]   r_pipe_tag [CSR_LATENCY];
  logic                   w_exit_vld;
  logic [c_ptr_w-1:0]     w_exit_ch;
  logic [TAG_WIDTH-1:0]   w_exit_tag;

  // Writes never wait; a read waits until its channel's previous read has been consumed.
  assign w_elig = req_valid & (req_rw | ~r_busy);

  // Round-robin search starting at the pointer; the first eligible channel wins.
  always_comb begin
    w_idx         = '0;
    w_grant_valid = 1'b0;
    w_grant_idx   = '0;
    for (int i = 0; i < NUM_TCU; i++) begin
      w_idx = {1'b0, r_rr} + c_idx_w'(i);
      if (w_idx >= c_idx_w'(NUM_TCU)) begin
        w_idx = w_idx - c_idx_w'(NUM_TCU);
      end
      if (!w_grant_valid && w_elig[w_idx[c_ptr_w-1:0]]) begin
        w_grant_valid = 1'b1;
        w_grant_idx   = w_idx[c_ptr_w-1:0];
      end
    end
  end

  assign w_grant_rw    = req_rw[w_grant_idx];
  assign w_rd_grant    = w_grant_valid & ~w_grant_rw;
  assign w_wr_grant    = w_grant_valid &  w_grant_rw;
  assign w_grant_addr  = req_addr[w_grant_idx*ADDR_BITS +: ADDR_BITS];
  assign w_grant_wdata = req_wdata[w_grant_idx*DATA_WIDTH +: DATA_WIDTH];
  assign w_grant_tag   = req_tag[w_grant_idx*TAG_WIDTH +: TAG_WIDTH];
  assign req_ready     = w_grant_valid ? (NUM_TCU'(1) << w_grant_idx) : '0;

  assign w_exit_vld = r_pipe_vld[CSR_LATENCY-1];
  assign w_exit_ch  = r_pipe_ch[CSR_LATENCY-1];
  assign w_exit_tag = r_pipe_tag[CSR_LATENCY-1];

  // Issue the granted access to the CSR one cycle after the grant and advance the pointer.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_rr             <= '0;
      csr_read_enable  <= 1'b0;
      csr_read_addr    <= '0;
      csr_write_enable <= 1'b0;
      csr_write_addr   <= '0;
      csr_write_data   <= '0;
    end else begin
      csr_read_enable  <= w_rd_grant;
      csr_write_enable <= w_wr_grant;
      if (w_rd_grant) begin
        csr_read_addr <= w_grant_addr;
      end
      if (w_wr_grant) begin
        csr_write_addr <= w_grant_addr;
        csr_write_data <= w_grant_wdata;
      end
      if (w_grant_valid) begin
        if (w_grant_idx == c_ptr_w'(NUM_TCU - 1)) begin
          r_rr <= '0;
        end else begin
          r_rr <= w_grant_idx + 1'b1;
        end
      end
    end
  end

  // Carry {channel, tag} alongside the CSR read and land the data in that channel's slot.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_pipe_vld <= '0;
      for (int k = 0; k < CSR_LATENCY; k++) begin
        r_pipe_ch[k]  <= '0;
        r_pipe_tag[k] <= '0;
      end
      r_busy     <= '0;
      rsp_valid  <= '0;
      rsp_data_a <= '0;
      rsp_data_b <= '0;
      rsp_tag    <= '0;
    end else begin
      r_pipe_vld[0] <= w_rd_grant;
      r_pipe_ch[0]  <= w_grant_idx;
      r_pipe_tag[0] <= w_grant_tag;
      for (int k = 1; k < CSR_LATENCY; k++) begin
        r_pipe_vld[k] <= r_pipe_vld[k-1];
        r_pipe_ch[k]  <= r_pipe_ch[k-1];
        r_pipe_tag[k] <= r_pipe_tag[k-1];
      end
      for (int ch = 0; ch < NUM_TCU; ch++) begin
        // Busy spans the whole read: grant through response handshake.
        if (w_rd_grant && (w_grant_idx == c_ptr_w'(ch))) begin
          r_busy[ch] <= 1'b1;
        end else if (rsp_valid[ch] && rsp_ready[ch]) begin
          r_busy[ch] <= 1'b0;
        end
        // The slot is always free on capture since a channel has one read in flight at most.
        if (w_exit_vld && (w_exit_ch == c_ptr_w'(ch))) begin
          rsp_valid[ch]                           <= 1'b1;
          rsp_data_a[ch*DATA_WIDTH +: DATA_WIDTH] <= csr_read_data_a;
          rsp_data_b[ch*DATA_WIDTH +: DATA_WIDTH] <= csr_read_data_b;
          rsp_tag[ch*TAG_WIDTH +: TAG_WIDTH]      <= w_exit_tag;
        end else if (rsp_valid[ch] && rsp_ready[ch]) begin
          rsp_valid[ch] <= 1'b0;
        end
      end
    end
  end

endmodule
`default_nettype wire
